// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. It resolves memory waits, multi-cycle MDU ops,
// taken-branch flushes and load-use hazards, and keeps a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_busy,
    input  logic             d_busy,
    input  logic             ex_memread,
    input  logic [4:0]       ex_wa,
    input  logic [4:0]       dec_ra1,
    input  logic [4:0]       dec_ra2,
    input  logic             dec_use1,
    input  logic             dec_use2,
    input  logic             ex_mdu_start,
    input  logic             branch_taken,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int                CW       = $clog2(MDU_LAT) + 1;
    localparam bit                MULTI    = (MDU_LAT > 1);
    localparam logic [CW-1:0]     CNT_INIT = MULTI ? CW'(MDU_LAT - 2) : '0;

    typedef enum logic [0:0] {S_RUN, S_MDU} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic lu;
    logic mdu_last;
    logic mdu_hold;

    always_comb begin
        lu = ex_memread && (ex_wa != 5'd0) &&
             ((dec_use1 && (dec_ra1 == ex_wa)) || (dec_use2 && (dec_ra2 == ex_wa)));
        mdu_last = (state_q == S_MDU) && (cnt_q == '0);
        mdu_hold = ((state_q == S_MDU) && !mdu_last) ||
                   ((state_q == S_RUN) && ex_mdu_start && MULTI);

        stallF   = 1'b0;
        stallD   = 1'b0;
        stallE   = 1'b0;
        stallM   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        mdu_done = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;

        if (d_busy) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else begin
            if (mdu_hold) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
            end else begin
                // Final MDU cycle releases the whole front end so D can follow the result out of E
                mdu_done = mdu_last || ((state_q == S_RUN) && ex_mdu_start && !MULTI);
                if ((state_q == S_RUN) && !ex_mdu_start && branch_taken) begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                    stallF = i_busy;
                end else if (lu) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end else if (i_busy) begin
                    stallF = 1'b1;
                    flushD = 1'b1;
                end
            end

            case (state_q)
                S_RUN: begin
                    if (ex_mdu_start && MULTI) begin
                        state_d = S_MDU;
                        cnt_d   = CNT_INIT;
                    end
                end
                S_MDU: begin
                    if (mdu_last) state_d = S_RUN;
                    else          cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = S_RUN;
            endcase
        end

        // Outputs are forced quiet for the whole time reset is held, not just after the edge
        if (!reset) begin
            stallF   = 1'b0;
            stallD   = 1'b0;
            stallE   = 1'b0;
            stallM   = 1'b0;
            flushD   = 1'b0;
            flushE   = 1'b0;
            mdu_done = 1'b0;
        end

        stall_cycles_d = stall_cycles_q;
        if (stallF && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_RUN;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule
